apb_rr_scheduler: RTL and testbench

- Shares one APB bus between N local requesters using round-robin arbitration.
- Sequences each granted request through APB SETUP/ACCESS phases and supports slave wait states via Pready.
- Returns read data plus a per-requester ack/err pulse, and aborts hung transfers with a timeout counter.
- Sits between on-chip command sources and the APB slaves, in place of a single-source master.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_rr_scheduler_if.sv | 33 +++
 rtl/apb_rr_pick.sv | 34 +++
 rtl/apb_rr_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_apb_rr_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and defaults for the APB round-robin scheduler
//               and related bus schedulers.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Default bus widths
  localparam int c_default_k = 8;
  localparam int c_default_a = 4;

  // Bus sequencer state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_scheduler_if
// Description : APB bus bundle between the scheduler (master) and a slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_rr_scheduler_if
  import apb_pkg::*;
#(
  parameter int K = c_default_k,
  parameter int A = c_default_a
);

  logic         Psel;
  logic         Penable;
  logic         Pwrite;
  logic [A-1:0] Paddress;
  logic [K-1:0] PWdata;
  logic [K-1:0] PRdata;
  logic         Pready;

  modport master (
    output Psel, Penable, Pwrite, Paddress, PWdata,
    input  PRdata, Pready
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddress, PWdata,
    output PRdata, Pready
  );

endinterface
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_pick
// Description : Combinational rotate-priority picker. Returns the first set
//               bit of eligible scanning from last_grant+1 upward, modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_pick #(
  parameter  int N    = 4,
  localparam int c_gw = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    eligible,
  input  logic [c_gw-1:0] last_grant,
  output logic            valid,
  output logic [c_gw-1:0] grant
);

  // Scan candidates in rotated order; the first hit wins
  always_comb begin
    logic [c_gw-1:0] w_idx;
    valid = 1'b0;
    grant = last_grant;
    w_idx = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = c_gw'((int'(last_grant) + i) % N);
      if (!valid && eligible[w_idx]) begin
        valid = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_scheduler
// Description : Shares one APB bus among N requesters with round-robin
//               arbitration, wait-state support and an ACCESS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_scheduler
  import apb_pkg::*;
#(
  parameter int N       = 4,
  parameter int K       = c_default_k,
  parameter int A       = c_default_a,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                Presetn,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        req_wr,
  input  logic [N*A-1:0]      req_addr,
  input  logic [N*K-1:0]      req_wdata,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        err,
  output logic [K-1:0]        rdata,
  apb_rr_scheduler_if.master  bus
);

  localparam int c_gw = (N > 1) ? $clog2(N) : 1;
  localparam int c_cw = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cw-1:0] c_cnt_last = (TIMEOUT > 0) ? c_cw'(TIMEOUT - 1) : '0;

  state_t          r_state,   w_state_nxt;
  logic [c_gw-1:0] r_grant,   w_grant_nxt;
  logic [c_gw-1:0] r_last,    w_last_nxt;
  logic            r_psel,    w_psel_nxt;
  logic            r_penable, w_penable_nxt;
  logic            r_pwrite,  w_pwrite_nxt;
  logic [A-1:0]    r_paddr,   w_paddr_nxt;
  logic [K-1:0]    r_pwdata,  w_pwdata_nxt;
  logic [K-1:0]    r_rdata,   w_rdata_nxt;
  logic [N-1:0]    r_ack,     w_ack_nxt;
  logic [N-1:0]    r_err,     w_err_nxt;
  logic [c_cw-1:0] r_cnt,     w_cnt_nxt;

  logic            w_timeout;
  logic            w_complete;
  logic [N-1:0]    w_grant_mask;
  logic [N-1:0]    w_done_mask;
  logic [N-1:0]    w_eligible;
  logic            w_pick_valid;
  logic [c_gw-1:0] w_pick;
  logic [A-1:0]    w_sel_addr;
  logic [K-1:0]    w_sel_wdata;
  logic            w_sel_wr;
  logic            w_load;

  // The completing requester and the one just acked may not win again
  assign w_timeout    = (r_state == ACCESS) && !bus.Pready && (TIMEOUT != 0) && (r_cnt == c_cnt_last);
  assign w_complete   = (r_state == ACCESS) && (bus.Pready || w_timeout);
  assign w_grant_mask = N'(1) << r_grant;
  assign w_done_mask  = w_complete ? w_grant_mask : '0;
  assign w_eligible   = req & ~r_ack & ~w_done_mask;

  apb_rr_pick #(.N(N)) u_pick (
    .eligible   (w_eligible),
    .last_grant (r_last),
    .valid      (w_pick_valid),
    .grant      (w_pick)
  );

  // Route the picked requester's command fields
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_pick == c_gw'(i)) begin
        w_sel_addr  = req_addr[i*A +: A];
        w_sel_wdata = req_wdata[i*K +: K];
        w_sel_wr    = req_wr[i];
      end
    end
  end

  // Next-state and next-output logic for the SETUP/ACCESS sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_rdata_nxt   = r_rdata;
    w_ack_nxt     = '0;
    w_err_nxt     = '0;
    w_cnt_nxt     = r_cnt;
    w_load        = 1'b0;

    case (r_state)
      IDLE: begin
        w_penable_nxt = 1'b0;
        if (w_pick_valid) begin
          w_load = 1'b1;
        end else begin
          w_psel_nxt = 1'b0;
        end
      end
      SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (bus.Pready) begin
          w_ack_nxt     = w_grant_mask;
          w_penable_nxt = 1'b0;
          if (!r_pwrite) begin
            w_rdata_nxt = bus.PRdata;
          end
          if (w_pick_valid) begin
            w_load = 1'b1;
          end else begin
            w_psel_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end else if (w_timeout) begin
          w_ack_nxt     = w_grant_mask;
          w_err_nxt     = w_grant_mask;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase

    // Latch a new grant; write data only replaced for writes
    if (w_load) begin
      w_grant_nxt   = w_pick;
      w_last_nxt    = w_pick;
      w_paddr_nxt   = w_sel_addr;
      w_pwrite_nxt  = w_sel_wr;
      if (w_sel_wr) begin
        w_pwdata_nxt = w_sel_wdata;
      end
      w_psel_nxt    = 1'b1;
      w_penable_nxt = 1'b0;
      w_state_nxt   = SETUP;
    end
  end

  // State and output registers; reset drops the bus immediately
  always_ff @(posedge PCLK or negedge Presetn) begin
    if (!Presetn) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= c_gw'(N - 1);
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.Psel     = r_psel;
  assign bus.Penable  = r_penable;
  assign bus.Pwrite   = r_pwrite;
  assign bus.Paddress = r_paddr;
  assign bus.PWdata   = r_pwdata;
  assign ack          = r_ack;
  assign err          = r_err;
  assign rdata        = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_rr_scheduler
// Description : Directed self-checking bench for apb_rr_scheduler with an
//               ack scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_scheduler;
  import apb_pkg::*;

  localparam int N       = 4;
  localparam int K       = 8;
  localparam int A       = 4;
  localparam int TIMEOUT = 16;

  logic           PCLK = 1'b0;
  logic           Presetn;
  logic [N-1:0]   req;
  logic [N-1:0]   req_wr;
  logic [N*A-1:0] req_addr;
  logic [N*K-1:0] req_wdata;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [K-1:0]   rdata;

  apb_rr_scheduler_if #(.K(K), .A(A)) bus ();

  apb_rr_scheduler #(.N(N), .K(K), .A(A), .TIMEOUT(TIMEOUT)) dut (
    .PCLK      (PCLK),
    .Presetn   (Presetn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int           idx;
    logic [N-1:0] errm;
    bit           chk_rd;
    logic [K-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   ord [6] = '{0, 1, 3, 0, 1, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [A-1:0] a, input logic [K-1:0] d);
    req_wr    = (req_wr & ~(N'(1) << i)) | (N'(wr) << i);
    req_addr  = (req_addr & ~((N*A)'({A{1'b1}}) << (i*A))) | ((N*A)'(a) << (i*A));
    req_wdata = (req_wdata & ~((N*K)'({K{1'b1}}) << (i*K))) | ((N*K)'(d) << (i*K));
  endtask

  task automatic push(input int idx, input bit is_err, input bit chk_rd, input logic [K-1:0] rd);
    exp_t e;
    e.idx    = idx;
    e.errm   = is_err ? (N'(1) << idx) : '0;
    e.chk_rd = chk_rd;
    e.rd     = rd;
    sb.push_back(e);
  endtask

  // Scoreboard: every ack pulse must match the next expected completion
  always @(negedge PCLK) begin
    if (Presetn === 1'b1 && (ack !== '0 || err !== '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack_err", 32'({ack, err}), 32'h0);
      end else begin
        m_e = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(1) << m_e.idx);
        chk("sb_err", 32'(err), 32'(m_e.errm));
        if (m_e.chk_rd) chk("sb_rdata", 32'(rdata), 32'(m_e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Presetn     = 1'b0;
    req         = '0;
    req_wr      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    bus.Pready  = 1'b0;
    bus.PRdata  = '0;
    tick();
    tick();
    chk("rst_psel",    32'(bus.Psel),     0);
    chk("rst_penable", 32'(bus.Penable),  0);
    chk("rst_pwrite",  32'(bus.Pwrite),   0);
    chk("rst_paddr",   32'(bus.Paddress), 0);
    chk("rst_pwdata",  32'(bus.PWdata),   0);
    chk("rst_ack",     32'(ack),          0);
    chk("rst_err",     32'(err),          0);
    chk("rst_rdata",   32'(rdata),        0);
    Presetn = 1'b1;
    tick();

    // Round robin 0,1,3,0,1,3 back-to-back, Psel continuously high
    set_req(0, 1'b1, 4'h4, 8'h10);
    set_req(1, 1'b1, 4'h5, 8'h11);
    set_req(3, 1'b1, 4'h7, 8'h13);
    bus.Pready = 1'b1;
    req = 4'b1011;
    for (int j = 0; j < 6; j++) push(ord[j], 1'b0, 1'b0, '0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 11) req = '0;
      chk("rr_psel", 32'(bus.Psel), 1);
      chk("rr_penable", 32'(bus.Penable), k % 2);
      if (k % 2 == 0) begin
        chk("rr_paddr",  32'(bus.Paddress), 4 + ord[k/2]);
        chk("rr_pwdata", 32'(bus.PWdata),   32'h10 + ord[k/2]);
      end
    end
    tick();
    chk("rr_last_ack", 32'(ack), 32'b1000);
    chk("rr_idle_psel", 32'(bus.Psel), 0);
    tick();

    // Read with three wait states
    set_req(2, 1'b0, 4'h9, 8'h00);
    bus.Pready = 1'b0;
    bus.PRdata = 8'hEE;
    req = 4'b0100;
    push(2, 1'b0, 1'b1, 8'h5C);
    tick();
    chk("rd_setup_psel",    32'(bus.Psel),     1);
    chk("rd_setup_penable", 32'(bus.Penable),  0);
    chk("rd_paddr",         32'(bus.Paddress), 32'h9);
    chk("rd_pwrite",        32'(bus.Pwrite),   0);
    chk("rd_pwdata_hold",   32'(bus.PWdata),   32'h13);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("rd_wait_penable", 32'(bus.Penable), 1);
      chk("rd_wait_ack",     32'(ack),         0);
    end
    tick();
    bus.Pready = 1'b1;
    bus.PRdata = 8'h5C;
    chk("rd_last_penable", 32'(bus.Penable), 1);
    tick();
    req = '0;
    bus.Pready = 1'b0;
    chk("rd_ack",   32'(ack),         32'b0100);
    chk("rd_rdata", 32'(rdata),       32'h5C);
    chk("rd_psel",  32'(bus.Psel),    0);
    tick();

    // Timeout on requester 1: abort after 16 ACCESS cycles
    set_req(1, 1'b0, 4'hA, 8'h00);
    bus.PRdata = 8'h77;
    req = 4'b0010;
    push(1, 1'b1, 1'b1, 8'h5C);
    tick();
    chk("to_psel",  32'(bus.Psel),     1);
    chk("to_paddr", 32'(bus.Paddress), 32'hA);
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("to_penable", 32'(bus.Penable), 1);
      chk("to_no_ack",  32'(ack),         0);
    end
    tick();
    chk("to_ack",     32'(ack),         32'b0010);
    chk("to_err",     32'(err),         32'b0010);
    chk("to_rdata",   32'(rdata),       32'h5C);
    chk("to_psel0",   32'(bus.Psel),    0);
    chk("to_penable0",32'(bus.Penable), 0);
    req = '0;

    // Next request after timeout served normally
    set_req(3, 1'b1, 4'hF, 8'h3C);
    bus.Pready = 1'b1;
    req = 4'b1000;
    push(3, 1'b0, 1'b0, '0);
    tick();
    chk("post_to_psel", 32'(bus.Psel), 1);
    tick();
    chk("post_to_penable", 32'(bus.Penable),  1);
    chk("post_to_paddr",   32'(bus.Paddress), 32'hF);
    chk("post_to_pwdata",  32'(bus.PWdata),   32'h3C);
    tick();
    chk("post_to_ack", 32'(ack), 32'b1000);
    chk("post_to_err", 32'(err), 0);
    req = '0;
    tick();

    // Single write, req held through the ack cycle: exactly one transfer
    set_req(0, 1'b1, 4'h3, 8'hA5);
    req = 4'b0001;
    push(0, 1'b0, 1'b0, '0);
    tick();
    chk("wr_psel",    32'(bus.Psel),    1);
    chk("wr_penable", 32'(bus.Penable), 0);
    tick();
    chk("wr_penable1", 32'(bus.Penable),  1);
    chk("wr_paddr",    32'(bus.Paddress), 32'h3);
    chk("wr_pwdata",   32'(bus.PWdata),   32'hA5);
    chk("wr_pwrite",   32'(bus.Pwrite),   1);
    tick();
    chk("wr_ack", 32'(ack), 32'b0001);
    chk("wr_err", 32'(err), 0);
    tick();
    req = '0;
    chk("nodbl_psel", 32'(bus.Psel), 0);
    tick();
    chk("nodbl_psel2", 32'(bus.Psel), 0);
    chk("nodbl_ack",   32'(ack),      0);

    // Reset during ACCESS drops the bus without a clock
    set_req(2, 1'b1, 4'h2, 8'h22);
    bus.Pready = 1'b0;
    req = 4'b0100;
    tick();
    tick();
    chk("mid_penable", 32'(bus.Penable), 1);
    #2;
    Presetn = 1'b0;
    #1;
    chk("mid_rst_psel",    32'(bus.Psel),    0);
    chk("mid_rst_penable", 32'(bus.Penable), 0);
    req = '0;
    tick();
    tick();
    Presetn = 1'b1;
    chk("mid_rst_ack", 32'(ack), 0);

    // After reset, requester 0 beats requester 3
    set_req(0, 1'b1, 4'h1, 8'h01);
    set_req(3, 1'b1, 4'hE, 8'hE3);
    bus.Pready = 1'b1;
    req = 4'b1001;
    push(0, 1'b0, 1'b0, '0);
    push(3, 1'b0, 1'b0, '0);
    tick();
    chk("prio_paddr",  32'(bus.Paddress), 32'h1);
    chk("prio_pwdata", 32'(bus.PWdata),   32'h01);
    tick();
    tick();
    req = 4'b1000;
    chk("prio_second_paddr", 32'(bus.Paddress), 32'hE);
    chk("prio_ack0",         32'(ack),          32'b0001);
    tick();
    req = '0;
    tick();
    chk("prio_ack3", 32'(ack),      32'b1000);
    tick();
    chk("final_psel", 32'(bus.Psel), 0);
    tick();
    chk("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
